// File: rtl/mul_share_arbiter.sv
// Round-robin front end that shares one sequential multiplier between NREQ clients.
// Each job runs IDLE -> ISSUE -> WAIT -> RESP. A multiplier that never finishes is
// cut off after TIMEOUT cycles in WAIT and answered with an error response.
module mul_share_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_multiplicand,
  input  logic [NREQ*WIDTH-1:0]    req_multiplier,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          done,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_error,
  output logic                     busy,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_multiplicand,
  output logic [WIDTH-1:0]         mul_multiplier,
  input  logic [2*WIDTH-1:0]       mul_product,
  input  logic                     mul_finish
);

  localparam int unsigned IdW = $clog2(NREQ);
  localparam int unsigned TW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic [IdW-1:0]       last_grant_q, last_grant_d;
  logic [IdW-1:0]       id_q, id_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [NREQ-1:0]      ack_q, ack_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic                 mul_start_q, mul_start_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic [2*WIDTH-1:0]   rsp_product_q, rsp_product_d;
  logic                 rsp_error_q, rsp_error_d;
  logic                 busy_q, busy_d;

  logic                 grant_vld;
  int unsigned          grant_idx;
  int unsigned          cand;

  // Round-robin pick: first requester above last_grant, wrapping at NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 0;
    cand      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last_grant_q) + k) % NREQ;
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Next-state and registered-output computation for the job sequencer.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    timer_d       = timer_q;
    ack_d         = '0;
    done_d        = '0;
    mul_start_d   = 1'b0;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    rsp_product_d = rsp_product_q;
    rsp_error_d   = rsp_error_q;

    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          id_d        = IdW'(grant_idx);
          mul_a_d     = req_multiplicand[grant_idx*WIDTH +: WIDTH];
          mul_b_d     = req_multiplier[grant_idx*WIDTH +: WIDTH];
          // ack and start are registered so they appear during ISSUE.
          ack_d       = NREQ'(1) << grant_idx;
          mul_start_d = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // Finish takes priority over a coincident timeout.
        if (mul_finish) begin
          rsp_product_d = mul_product;
          rsp_error_d   = 1'b0;
          done_d        = NREQ'(1) << id_q;
          state_d       = StResp;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_product_d = '0;
          rsp_error_d   = 1'b1;
          done_d        = NREQ'(1) << id_q;
          state_d       = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        last_grant_d = id_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      last_grant_q  <= IdW'(NREQ - 1);
      id_q          <= '0;
      timer_q       <= '0;
      ack_q         <= '0;
      done_q        <= '0;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      rsp_product_q <= '0;
      rsp_error_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      id_q          <= id_d;
      timer_q       <= timer_d;
      ack_q         <= ack_d;
      done_q        <= done_d;
      mul_start_q   <= mul_start_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      rsp_product_q <= rsp_product_d;
      rsp_error_q   <= rsp_error_d;
      busy_q        <= busy_d;
    end
  end

  assign ack              = ack_q;
  assign done             = done_q;
  assign rsp_product      = rsp_product_q;
  assign rsp_id           = id_q;
  assign rsp_error        = rsp_error_q;
  assign busy             = busy_q;
  assign mul_start        = mul_start_q;
  assign mul_multiplicand = mul_a_q;
  assign mul_multiplier   = mul_b_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: directed scenarios followed by random jobs,
// with expected grants, products and timing taken from a simple job-level model.
module tb_mul_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TO   = 64;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NREQ-1:0]      req;
  logic [NREQ*W-1:0]    req_multiplicand;
  logic [NREQ*W-1:0]    req_multiplier;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      done;
  logic [2*W-1:0]       rsp_product;
  logic [1:0]           rsp_id;
  logic                 rsp_error;
  logic                 busy;
  logic                 mul_start;
  logic [W-1:0]         mul_multiplicand;
  logic [W-1:0]         mul_multiplier;
  logic [2*W-1:0]       mul_product;
  logic                 mul_finish;

  int n_checks = 0;
  int n_errors = 0;

  // Job-level model state
  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];
  int           last_grant;
  int           wait_jobs [NREQ];

  mul_share_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .req              (req),
    .req_multiplicand (req_multiplicand),
    .req_multiplier   (req_multiplier),
    .ack              (ack),
    .done             (done),
    .rsp_product      (rsp_product),
    .rsp_id           (rsp_id),
    .rsp_error        (rsp_error),
    .busy             (busy),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_product      (mul_product),
    .mul_finish       (mul_finish)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_arr[i] = a;
    b_arr[i] = b;
    req_multiplicand[i*W +: W] = a;
    req_multiplier[i*W +: W]   = b;
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= NREQ; k++) begin
      if (req[(last_grant + k) % NREQ]) return (last_grant + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ack"}, 64'(ack), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    check_val({tag, "_start"}, 64'(mul_start), 64'd0);
    check_val({tag, "_err"}, 64'(rsp_error), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_prod"}, rsp_product, 64'd0);
    check_val({tag, "_id"}, 64'(rsp_id), 64'd0);
    check_val({tag, "_mula"}, 64'(mul_multiplicand), 64'd0);
    check_val({tag, "_mulb"}, 64'(mul_multiplier), 64'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    last_grant = NREQ - 1;
    for (int i = 0; i < NREQ; i++) wait_jobs[i] = 0;
  endtask

  // One complete job from IDLE. fin_at < 0 means the multiplier never finishes;
  // otherwise finish is pulsed in WAIT cycle fin_at (0-based).
  task automatic run_job(input int fin_at, input bit fin_in_issue, input bit keep);
    int          g;
    int          n;
    logic [63:0] exp_p;
    logic        exp_err;
    g = model_grant();
    if (g < 0) begin
      check_val("no_request", 64'd0, 64'd1);
      return;
    end
    exp_err = (fin_at < 0);
    exp_p   = exp_err ? 64'd0 : {32'd0, a_arr[g]} * {32'd0, b_arr[g]};
    tick();  // arbitration edge; now in ISSUE
    check_val("ack", 64'(ack), 64'(1) << g);
    check_val("start", 64'(mul_start), 64'd1);
    check_val("mula", 64'(mul_multiplicand), 64'(a_arr[g]));
    check_val("mulb", 64'(mul_multiplier), 64'(b_arr[g]));
    check_val("grant_id", 64'(rsp_id), 64'(g));
    check_val("busy_issue", 64'(busy), 64'd1);
    if (!keep) req[g] = 1'b0;
    if (fin_in_issue) begin
      mul_finish  = 1'b1;
      mul_product = 64'hDEAD_BEEF_0BAD_F00D;
    end
    tick();  // now in WAIT cycle 0
    mul_finish = 1'b0;
    check_val("ack_clr", 64'(ack), 64'd0);
    check_val("start_clr", 64'(mul_start), 64'd0);
    check_val("done_wait", 64'(done), 64'd0);
    if (fin_at >= 0) begin
      repeat (fin_at) tick();
      mul_product = {32'd0, mul_multiplicand} * {32'd0, mul_multiplier};
      mul_finish  = 1'b1;
      tick();
      mul_finish  = 1'b0;
    end else begin
      n = 0;
      while (done == '0 && n < 200) begin
        tick();
        n++;
      end
      check_val("timeout_cycles", 64'(n), 64'(TO));
    end
    check_val("done", 64'(done), 64'(1) << g);
    check_val("rsp_product", rsp_product, exp_p);
    check_val("rsp_id", 64'(rsp_id), 64'(g));
    check_val("rsp_error", 64'(rsp_error), 64'(exp_err));
    tick();  // back in IDLE
    check_val("done_clr", 64'(done), 64'd0);
    check_val("busy_idle", 64'(busy), 64'd0);
    check_val("rsp_hold", rsp_product, exp_p);
    last_grant = g;
  endtask

  logic [NREQ-1:0] req_before;
  int              g_exp;

  initial begin
    rstn = 1'b0;
    req = '0;
    req_multiplicand = '0;
    req_multiplier = '0;
    mul_finish = 1'b0;
    mul_product = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
      wait_jobs[i] = 0;
    end
    last_grant = NREQ - 1;
    #2;
    tick();
    tick();
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();
    check_val("idle_no_req", 64'(busy), 64'd0);

    // Single job: 3 * 5, finish two cycles after start
    set_ops(0, 32'd3, 32'd5);
    req = 4'b0001;
    run_job(1, 1'b0, 1'b0);
    check_val("single_15", rsp_product, 64'd15);

    // Round-robin with all requesters held
    for (int i = 0; i < NREQ; i++) set_ops(i, W'(i + 1), 32'd10);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) run_job(0, 1'b0, 1'b1);
    req = '0;

    // Wrap after reset
    do_reset();
    set_ops(1, 32'd6, 32'd7);
    set_ops(3, 32'd8, 32'd9);
    req = 4'b1010;
    for (int j = 0; j < 3; j++) run_job(0, 1'b0, 1'b1);
    req = '0;

    // Timeout, then a normal job
    set_ops(2, 32'd7, 32'd9);
    req = 4'b0100;
    run_job(-1, 1'b0, 1'b0);
    set_ops(1, 32'd1234, 32'd5678);
    req = 4'b0010;
    run_job(3, 1'b0, 1'b0);

    // Finish during ISSUE must be ignored
    set_ops(3, 32'd21, 32'd2);
    req = 4'b1000;
    run_job(2, 1'b1, 1'b0);

    // Finish on the final timeout cycle wins
    set_ops(0, 32'd100, 32'd200);
    req = 4'b0001;
    run_job(TO - 1, 1'b0, 1'b0);

    // Largest operands
    set_ops(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req = 4'b0010;
    run_job(0, 1'b0, 1'b0);
    check_val("max_prod", rsp_product, 64'hFFFF_FFFE_0000_0001);

    // Reset in WAIT: everything clears at once, no done follows
    set_ops(0, 32'd11, 32'd13);
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check_reset_outputs("midjob");
    tick();
    check_val("midjob_nodone", 64'(done), 64'd0);
    rstn = 1'b1;
    last_grant = NREQ - 1;
    for (int i = 0; i < NREQ; i++) wait_jobs[i] = 0;
    set_ops(2, 32'd3, 32'd3);
    req = 4'b0100;
    run_job(1, 1'b0, 1'b0);

    // Random jobs with fairness tracking
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          set_ops(i, $urandom, $urandom);
          req[i] = 1'b1;
        end
      end
      if (req == '0) begin
        set_ops(0, $urandom, $urandom);
        req[0] = 1'b1;
      end
      req_before = req;
      g_exp = model_grant();
      run_job(int'($urandom_range(0, 8)), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 3) == 0));
      for (int i = 0; i < NREQ; i++) begin
        if (i == g_exp || !req_before[i]) begin
          wait_jobs[i] = 0;
        end else begin
          wait_jobs[i]++;
          check_val("fairness", 64'(wait_jobs[i] < NREQ), 64'd1);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one sequential multiplier (start/finish handshake, 64-bit product) between NREQ requesters.
- Uses round-robin arbitration and sequences the start pulse for each job.
- Times out a multiplier that never asserts finish.
- Returns each product, tagged with the requester id, back to the requester that issued the job.
- Sits between the client blocks and the multiplier core; the multiplier's own operand inputs and start are driven only by this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, operand width; product width is 2*WIDTH.
- TIMEOUT, 64, max cycles spent in WAIT before declaring error (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request, level; held with stable operands until ack.
- req_multiplicand  input  NREQ*WIDTH  packed operand A; slice i belongs to requester i.
- req_multiplier  input  NREQ*WIDTH  packed operand B; slice i belongs to requester i.
- ack  output  NREQ  one-cycle pulse: request i accepted, operands latched.
- done  output  NREQ  one-cycle pulse: result for requester i valid on rsp_*.
- rsp_product  output  2*WIDTH  result product (0 on error).
- rsp_id  output  $clog2(NREQ)  id of the requester being answered.
- rsp_error  output  1  high with done when the job timed out.
- busy  output  1  high in any state other than IDLE.
- mul_start  output  1  one-cycle start pulse to the multiplier.
- mul_multiplicand  output  WIDTH  latched operand A, stable from ISSUE through WAIT.
- mul_multiplier  output  WIDTH  latched operand B, stable from ISSUE through WAIT.
- mul_product  input  2*WIDTH  multiplier result, sampled when mul_finish is high.
- mul_finish  input  1  multiplier completion pulse.

Behaviour:
- All outputs are registered.
- Reset (async, any state): state=IDLE; ack, done, mul_start, rsp_error, busy = 0; rsp_product, rsp_id, mul operand registers = 0; last_grant = NREQ-1, so requester 0 has top priority after reset.
- Reset mid-job abandons the job with no done pulse; the multiplier shares rstn.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If req != 0, grant the first set bit searching from last_grant+1 upward, wrapping at NREQ.
  - Latch that requester's operands into mul_* and its id into rsp_id; go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE (exactly 1 cycle): ack[id]=1 and mul_start=1 in the same cycle; clear timer; go to WAIT.
- WAIT:
  - If mul_finish: capture mul_product into rsp_product, rsp_error=0, go to RESP.
  - Else if timer==TIMEOUT-1: rsp_product=0, rsp_error=1, go to RESP.
  - Else timer++.
  - If mul_finish and the timeout coincide, finish wins.
- RESP (exactly 1 cycle): done[id]=1; rsp_product, rsp_id and rsp_error are valid; last_grant=id; go to IDLE.
- rsp_product, rsp_id and rsp_error hold their values until the next job's capture.
- mul_finish outside WAIT (including one in the ISSUE cycle) is ignored.
- Latency:
  - req seen in IDLE at cycle T -> ack/mul_start at T+1.
  - mul_finish at cycle F -> done at F+1.
  - Minimum request-to-request spacing is 4 cycles with an immediate finish.
- Requester rule: deassert req in the cycle after ack, unless another job is wanted. A req still high when the arbiter returns to IDLE is treated as a new job.
- Fairness: any continuously asserted req is granted within NREQ jobs.
- ack and done are one-hot or zero; never more than one bit set.
- Arithmetic: the block performs no arithmetic on operands; the only counter is a timer of $clog2(TIMEOUT) bits.

Test Plan:
- Single job: req=0001, A=3, B=5, mul model finishes 2 cycles after start -> ack=0001 one cycle after req; mul_start same cycle; done=0001, rsp_product=15, rsp_id=0, rsp_error=0.
- Round-robin: req=1111 held continuously with A_i=i+1, B_i=10 -> grants in order 0,1,2,3,0; products 10,20,30,40; each done goes to the matching id.
- Wrap after reset: after rstn pulse, req=1010 -> first grant id 1, next grant id 3, then id 1.
- Timeout: mul_finish never asserted, TIMEOUT=64 -> done one cycle after the 64th WAIT cycle, rsp_error=1, rsp_product=0; the next job then completes normally.
- Edge cases:
  - mul_finish in the ISSUE cycle is ignored and the arbiter stays in WAIT.
  - mul_finish coinciding with the last timeout cycle -> rsp_error=0, product captured.
  - A=FFFFFFFF, B=FFFFFFFF -> rsp_product=FFFFFFFE00000001.
- Reset mid-job: rstn low during WAIT -> all outputs 0 asynchronously, no done pulse; after release, req=0100 is granted first.
